// File: rtl/dram_cmd_scheduler_if.sv
// Request and command bundle for dram_cmd_scheduler.
// Latency: none (wires only); the scheduler registers every cmd_* field.
// Backpressure: req_valid_in/req_ready_out handshake; the cmd_* side is a one-cycle strobe with no ready.
// Ports: req_valid_in, req_ready_out, req_write_in, req_bg_in, req_ba_in, req_row_in, req_col_in,
//        req_data_in, cmd_valid_out, cmd_out, bank_group_out, bank_out, row_out, col_out, wdata_out.
// Modports: slave = scheduler view, master = request source / command sink view.
interface dram_cmd_scheduler_if #(
  parameter int BANK_GROUPS     = 2,
  parameter int BANKS_PER_GROUP = 4,
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 4
);
  localparam int BG_W = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1;
  localparam int BA_W = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1;

  logic                req_valid_in;
  logic                req_ready_out;
  logic                req_write_in;
  logic [BG_W-1:0]     req_bg_in;
  logic [BA_W-1:0]     req_ba_in;
  logic [ROW_BITS-1:0] req_row_in;
  logic [COL_BITS-1:0] req_col_in;
  logic [7:0][63:0]    req_data_in;

  logic                cmd_valid_out;
  logic [2:0]          cmd_out;
  logic [BG_W-1:0]     bank_group_out;
  logic [BA_W-1:0]     bank_out;
  logic [ROW_BITS-1:0] row_out;
  logic [COL_BITS-1:0] col_out;
  logic [7:0][63:0]    wdata_out;

  modport slave (
    input  req_valid_in, req_write_in, req_bg_in, req_ba_in, req_row_in, req_col_in, req_data_in,
    output req_ready_out, cmd_valid_out, cmd_out, bank_group_out, bank_out, row_out, col_out,
           wdata_out
  );

  modport master (
    output req_valid_in, req_write_in, req_bg_in, req_ba_in, req_row_in, req_col_in, req_data_in,
    input  req_ready_out, cmd_valid_out, cmd_out, bank_group_out, bank_out, row_out, col_out,
           wdata_out
  );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Turns one memory request at a time into PRECHARGE/ACTIVATE/READ/WRITE commands (open-page policy).
// Latency: first command one cycle after accept when no timer blocks; each command is a registered one-cycle strobe.
// Backpressure: req_ready_out is high only while idle, so one request is in flight at a time.
// Ports: clk_in, rst_in (async, active-high), bus (dram_cmd_scheduler_if.slave: request handshake + command strobe).
// Optional: DRAM_SCHED_PERF_EN adds row_hit_count_out / row_miss_count_out (saturating 32-bit accept counters).
module dram_cmd_scheduler #(
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BURST_CYCLES       = 4,
  parameter int BANK_GROUPS        = 2,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  dram_cmd_scheduler_if.slave  bus
`ifdef DRAM_SCHED_PERF_EN
  ,
  output logic [31:0]          row_hit_count_out,
  output logic [31:0]          row_miss_count_out
`endif
);
  localparam int BG_W  = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1;
  localparam int BA_W  = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1;
  localparam int NB    = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  // Timers are loaded with latency-1: a load at the issuing edge reaches 0 just
  // before the edge that is exactly <latency> cycles later.
  localparam int BT_MAX = ((ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                           ACTIVATION_LATENCY : PRECHARGE_LATENCY) - 1;
  localparam int BT_W   = (BT_MAX > 1) ? $clog2(BT_MAX + 1) : 1;
  localparam int BUS_W  = (BURST_CYCLES > 2) ? $clog2(BURST_CYCLES) : 1;
  localparam int DR_W   = $clog2(CAS_LATENCY + BURST_CYCLES);

  localparam logic [2:0] CMD_RD  = 3'd0;
  localparam logic [2:0] CMD_WR  = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_PRE = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ACT, S_RW} state_t;

  state_t              state_q;
  logic                ready_q;

  // Latched request
  logic                lat_write_q;
  logic [BG_W-1:0]     lat_bg_q;
  logic [BA_W-1:0]     lat_ba_q;
  logic [ROW_BITS-1:0] lat_row_q;
  logic [COL_BITS-1:0] lat_col_q;
  logic [7:0][63:0]    lat_data_q;

  // Per-bank page state and timers
  logic                bank_open_q [NB];
  logic [ROW_BITS-1:0] bank_row_q  [NB];
  logic [BT_W-1:0]     bank_tmr_q  [NB];
  logic [BT_W-1:0]     bank_tmr_d  [NB];

  // Shared data-bus timers
  logic [BUS_W-1:0]    bus_tmr_q, bus_tmr_d;
  logic [DR_W-1:0]     rd_drain_q, rd_drain_d;

  // Registered command outputs
  logic                cmd_valid_q;
  logic [2:0]          cmd_q;
  logic [BG_W-1:0]     bg_out_q;
  logic [BA_W-1:0]     ba_out_q;
  logic [ROW_BITS-1:0] row_out_q;
  logic [COL_BITS-1:0] col_out_q;
  logic [7:0][63:0]    wdata_q;

  logic [IDX_W-1:0]    acc_idx, cur_idx;
  logic                accept, acc_hit, tmr_zero;
  logic                issue_pre, issue_act, issue_rw;

  always_comb begin
    acc_idx   = IDX_W'(int'(bus.req_bg_in) * BANKS_PER_GROUP + int'(bus.req_ba_in));
    cur_idx   = IDX_W'(int'(lat_bg_q) * BANKS_PER_GROUP + int'(lat_ba_q));
    accept    = bus.req_valid_in && ready_q;
    acc_hit   = bank_open_q[acc_idx] && (bank_row_q[acc_idx] == bus.req_row_in);
    tmr_zero  = (bank_tmr_q[cur_idx] == '0);
    issue_pre = (state_q == S_PRE) && tmr_zero;
    issue_act = (state_q == S_ACT) && tmr_zero;
    // A WRITE must also wait for the read data of an earlier READ to leave the bus.
    issue_rw  = (state_q == S_RW) && tmr_zero && (bus_tmr_q == '0) &&
                (!lat_write_q || (rd_drain_q == '0));

    for (int b = 0; b < NB; b++) begin
      bank_tmr_d[b] = (bank_tmr_q[b] != '0) ? bank_tmr_q[b] - BT_W'(1) : '0;
      if (IDX_W'(b) == cur_idx) begin
        if (issue_pre) bank_tmr_d[b] = BT_W'(PRECHARGE_LATENCY - 1);
        if (issue_act) bank_tmr_d[b] = BT_W'(ACTIVATION_LATENCY - 1);
      end
    end

    bus_tmr_d = (bus_tmr_q != '0) ? bus_tmr_q - BUS_W'(1) : '0;
    if (issue_rw) bus_tmr_d = BUS_W'(BURST_CYCLES - 1);

    rd_drain_d = (rd_drain_q != '0) ? rd_drain_q - DR_W'(1) : '0;
    if (issue_rw && !lat_write_q) rd_drain_d = DR_W'(CAS_LATENCY + BURST_CYCLES - 1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      lat_write_q <= 1'b0;
      lat_bg_q    <= '0;
      lat_ba_q    <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      lat_data_q  <= '0;
      for (int b = 0; b < NB; b++) begin
        bank_open_q[b] <= 1'b0;
        bank_row_q[b]  <= '0;
        bank_tmr_q[b]  <= '0;
      end
      bus_tmr_q   <= '0;
      rd_drain_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      bg_out_q    <= '0;
      ba_out_q    <= '0;
      row_out_q   <= '0;
      col_out_q   <= '0;
      wdata_q     <= '0;
    end else begin
      bank_tmr_q  <= bank_tmr_d;
      bus_tmr_q   <= bus_tmr_d;
      rd_drain_q  <= rd_drain_d;
      cmd_valid_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            ready_q     <= 1'b0;
            lat_write_q <= bus.req_write_in;
            lat_bg_q    <= bus.req_bg_in;
            lat_ba_q    <= bus.req_ba_in;
            lat_row_q   <= bus.req_row_in;
            lat_col_q   <= bus.req_col_in;
            lat_data_q  <= bus.req_data_in;
            if (acc_hit)                   state_q <= S_RW;
            else if (bank_open_q[acc_idx]) state_q <= S_PRE;
            else                           state_q <= S_ACT;
          end
        end
        S_PRE: begin
          if (issue_pre) begin
            cmd_valid_q          <= 1'b1;
            cmd_q                <= CMD_PRE;
            bg_out_q             <= lat_bg_q;
            ba_out_q             <= lat_ba_q;
            bank_open_q[cur_idx] <= 1'b0;
            state_q              <= S_ACT;
          end
        end
        S_ACT: begin
          if (issue_act) begin
            cmd_valid_q          <= 1'b1;
            cmd_q                <= CMD_ACT;
            bg_out_q             <= lat_bg_q;
            ba_out_q             <= lat_ba_q;
            row_out_q            <= lat_row_q;
            bank_open_q[cur_idx] <= 1'b1;
            bank_row_q[cur_idx]  <= lat_row_q;
            state_q              <= S_RW;
          end
        end
        S_RW: begin
          if (issue_rw) begin
            cmd_valid_q <= 1'b1;
            cmd_q       <= lat_write_q ? CMD_WR : CMD_RD;
            bg_out_q    <= lat_bg_q;
            ba_out_q    <= lat_ba_q;
            col_out_q   <= lat_col_q;
            if (lat_write_q) wdata_q <= lat_data_q;
            ready_q     <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_out  = ready_q;
  assign bus.cmd_valid_out  = cmd_valid_q;
  assign bus.cmd_out        = cmd_q;
  assign bus.bank_group_out = bg_out_q;
  assign bus.bank_out       = ba_out_q;
  assign bus.row_out        = row_out_q;
  assign bus.col_out        = col_out_q;
  assign bus.wdata_out      = wdata_q;

`ifdef DRAM_SCHED_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Classified at accept: a hit needs no ACTIVATE, closed and conflict both do.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (acc_hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign row_hit_count_out  = hit_cnt_q;
  assign row_miss_count_out = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler: page hit/closed/conflict sequences, bus spacing, reset abort.
// Inputs driven on the falling edge, outputs sampled on the falling edge; cyc counts rising edges.
// Expected command cycles are computed from the accept cycle and the latency parameters.
module tb_dram_cmd_scheduler;
  logic clk_in;
  logic rst_in;
  int   cyc;
  int   errors;
  int   checks;

  dram_cmd_scheduler_if bus ();

`ifdef DRAM_SCHED_PERF_EN
  logic [31:0] row_hit_count_out;
  logic [31:0] row_miss_count_out;
  dram_cmd_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus),
    .row_hit_count_out(row_hit_count_out), .row_miss_count_out(row_miss_count_out)
  );
`else
  dram_cmd_scheduler dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
`endif

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge right after the accept edge.
  task automatic send_req(input logic w, input logic [0:0] bg, input logic [1:0] ba,
                          input logic [7:0] row, input logic [3:0] col,
                          input logic [7:0][63:0] d, output int t_acc);
    int n;
    bus.req_valid_in = 1'b1;
    bus.req_write_in = w;
    bus.req_bg_in    = bg;
    bus.req_ba_in    = ba;
    bus.req_row_in   = row;
    bus.req_col_in   = col;
    bus.req_data_in  = d;
    n = 0;
    while (!bus.req_ready_out && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    @(negedge clk_in);
    t_acc = cyc;
    bus.req_valid_in = 1'b0;
    if (n >= 200) check("req_ready_timeout", 512'(0), 512'(1));
  endtask

  // Returns on the falling edge where the next command strobe is seen; t=-1 on timeout.
  task automatic wait_cmd(output int t, output logic [2:0] c);
    int  n;
    bit  got;
    t   = -1;
    c   = 3'd7;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk_in);
      n++;
      if (bus.cmd_valid_out) begin
        got = 1'b1;
        t   = cyc;
        c   = bus.cmd_out;
      end
    end
  endtask

  int               t0, u, v, a, rd_t, w, v2, a2, t1, seen, exp_t;
  logic [2:0]       c;
  logic [7:0][63:0] wline;
  logic [7:0][63:0] zline;

  initial begin
    errors = 0;
    checks = 0;
    zline  = '0;
    for (int i = 0; i < 8; i++) wline[i] = {32'hC0DE_0000 | 32'(i), 32'h1234_5678 + 32'(i)};
    rst_in           = 1'b1;
    bus.req_valid_in = 1'b0;
    bus.req_write_in = 1'b0;
    bus.req_bg_in    = '0;
    bus.req_ba_in    = '0;
    bus.req_row_in   = '0;
    bus.req_col_in   = '0;
    bus.req_data_in  = '0;
    repeat (3) @(negedge clk_in);

    // Reset state
    check("rst_ready", bus.req_ready_out, 1);
    check("rst_cmd_valid", bus.cmd_valid_out, 0);
    check("rst_cmd", bus.cmd_out, 0);
    check("rst_row", bus.row_out, 0);
    check("rst_col", bus.col_out, 0);
    check("rst_wdata", bus.wdata_out, 0);
`ifdef DRAM_SCHED_PERF_EN
    check("rst_hit_cnt", row_hit_count_out, 0);
    check("rst_miss_cnt", row_miss_count_out, 0);
`endif
    rst_in = 1'b0;
    @(negedge clk_in);

    // Closed bank: ACTIVATE at T+1, READ at T+1+8
    send_req(1'b0, 1'b0, 2'd0, 8'd5, 4'd2, zline, t0);
    wait_cmd(t1, c);
    check("s1_act_time", t1, t0 + 1);
    check("s1_act_cmd", c, 2);
    check("s1_act_row", bus.row_out, 5);
    check("s1_act_bg", bus.bank_group_out, 0);
    check("s1_act_ba", bus.bank_out, 0);
    wait_cmd(t1, c);
    check("s1_rd_time", t1, t0 + 9);
    check("s1_rd_cmd", c, 0);
    check("s1_rd_col", bus.col_out, 2);
    @(negedge clk_in);
    check("s1_ready", bus.req_ready_out, 1);

    // Page hit: READ only, spaced at least BURST_CYCLES from the previous READ
    send_req(1'b0, 1'b0, 2'd0, 8'd5, 4'd3, zline, u);
    wait_cmd(t1, c);
    exp_t = (u + 1 > t0 + 13) ? u + 1 : t0 + 13;
    check("s2_rd_time", t1, exp_t);
    check("s2_rd_cmd", c, 0);
    check("s2_rd_col", bus.col_out, 3);

    // Row conflict: PRECHARGE V+1, ACTIVATE V+6, READ V+14
    send_req(1'b0, 1'b0, 2'd0, 8'd9, 4'd7, zline, v);
    wait_cmd(t1, c);
    check("s3_pre_time", t1, v + 1);
    check("s3_pre_cmd", c, 3);
    wait_cmd(t1, c);
    check("s3_act_time", t1, v + 6);
    check("s3_act_cmd", c, 2);
    check("s3_act_row", bus.row_out, 9);
    wait_cmd(t1, c);
    check("s3_rd_time", t1, v + 14);
    check("s3_rd_cmd", c, 0);
    check("s3_rd_col", bus.col_out, 7);
`ifdef DRAM_SCHED_PERF_EN
    check("perf_hit_cnt", row_hit_count_out, 1);
    check("perf_miss_cnt", row_miss_count_out, 2);
`endif

    // READ then WRITE on bg1 ba2: WRITE waits CAS_LATENCY+BURST_CYCLES after the READ
    send_req(1'b0, 1'b1, 2'd2, 8'd1, 4'd4, zline, a);
    wait_cmd(t1, c);
    check("s4_act_time", t1, a + 1);
    check("s4_act_cmd", c, 2);
    wait_cmd(rd_t, c);
    check("s4_rd_time", rd_t, a + 9);
    check("s4_rd_cmd", c, 0);
    send_req(1'b1, 1'b1, 2'd2, 8'd1, 4'd5, wline, w);
    wait_cmd(t1, c);
    check("s4_wr_gap", t1 - rd_t, 26);
    check("s4_wr_cmd", c, 1);
    check("s4_wr_col", bus.col_out, 5);
    check("s4_wr_bg", bus.bank_group_out, 1);
    check("s4_wr_ba", bus.bank_out, 2);
    check("s4_wdata", bus.wdata_out, wline);
    repeat (5) @(negedge clk_in);
    check("s4_wdata_hold", bus.wdata_out, wline);

    // Reset while waiting to ACTIVATE after a PRECHARGE
    send_req(1'b0, 1'b0, 2'd0, 8'd3, 4'd0, zline, v2);
    wait_cmd(t1, c);
    check("s5_pre_time", t1, v2 + 1);
    check("s5_pre_cmd", c, 3);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("s5_rst_cmd_valid", bus.cmd_valid_out, 0);
    check("s5_rst_ready", bus.req_ready_out, 1);
    @(negedge clk_in);
    rst_in = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk_in);
      if (bus.cmd_valid_out) seen++;
    end
    check("s5_no_cmd_after_rst", seen, 0);
`ifdef DRAM_SCHED_PERF_EN
    check("s5_hit_cnt_cleared", row_hit_count_out, 0);
    check("s5_miss_cnt_cleared", row_miss_count_out, 0);
`endif
    // bg1 ba2 row 1 was open before reset; it must now be treated as closed
    send_req(1'b0, 1'b1, 2'd2, 8'd1, 4'd6, zline, a2);
    wait_cmd(t1, c);
    check("s5_act_time", t1, a2 + 1);
    check("s5_act_cmd", c, 2);
    check("s5_act_row", bus.row_out, 1);
    wait_cmd(t1, c);
    check("s5_rd_time", t1, a2 + 9);
    check("s5_rd_cmd", c, 0);
    check("s5_rd_col", bus.col_out, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Sequences single memory requests into DIMM command streams (PRECHARGE / ACTIVATE / READ / WRITE) for the command sender.
- Keeps per-bank open-row state and per-bank timing counters; enforces activation, precharge and data-bus occupancy spacing.
- Sits between the request queue (upstream) and the command sender (downstream). Open-page policy.

Parameters:
- CAS_LATENCY, 22, cycles from READ command to first read data beat
- ACTIVATION_LATENCY, 8, cycles from ACTIVATE to next command on same bank
- PRECHARGE_LATENCY, 5, cycles from PRECHARGE to next command on same bank
- BURST_CYCLES, 4, data-bus occupancy of one 8-beat burst (DDR)
- BANK_GROUPS, 2, number of bank groups
- BANKS_PER_GROUP, 4, banks per group
- ROW_BITS, 8, row address width
- COL_BITS, 4, column address width

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous reset, active-high
- req_valid_in  in  1  request present
- req_ready_out  out  1  scheduler can accept request
- req_write_in  in  1  1=write, 0=read
- req_bg_in  in  $clog2(BANK_GROUPS)  bank group
- req_ba_in  in  $clog2(BANKS_PER_GROUP)  bank
- req_row_in  in  ROW_BITS  row
- req_col_in  in  COL_BITS  column
- req_data_in  in  [7:0][63:0]  write line
- cmd_valid_out  out  1  command valid this cycle
- cmd_out  out  3  0=READ 1=WRITE 2=ACTIVATE 3=PRECHARGE
- bank_group_out  out  $clog2(BANK_GROUPS)  target bank group
- bank_out  out  $clog2(BANKS_PER_GROUP)  target bank
- row_out  out  ROW_BITS  row (ACTIVATE)
- col_out  out  COL_BITS  column (READ/WRITE)
- wdata_out  out  [7:0][63:0]  write line, held stable from WRITE issue until next accept

Behaviour:
- Reset: state IDLE, all banks closed, all bank timers and bus timers 0. Outputs: req_ready_out=1, cmd_valid_out=0, cmd_out=0, addresses and wdata_out=0. Reset mid-sequence abandons the latched request; no further commands are issued.
- Handshake: accept on the rising edge where req_valid_in && req_ready_out. At that edge, latch all req_* fields. req_ready_out=1 only in IDLE. At most one request is in flight.
- FSM states: IDLE, PRE, ACT, RW.
- Transitions from IDLE on accept:
  - Bank open with same row (hit): go to RW.
  - Bank open with different row (conflict): go to PRE.
  - Bank closed: go to ACT.
- PRE:
  - When the bank timer is 0, assert cmd_valid_out for 1 cycle with PRECHARGE.
  - Mark the bank closed; go to ACT.
- ACT:
  - When the bank timer is 0, issue ACTIVATE with row_out=latched row.
  - Record the open row; go to RW.
- RW:
  - READ issues when bank timer==0 and bus_timer==0.
  - WRITE additionally requires rd_drain==0.
  - On issue, go to IDLE.
- Timing requirements:
  - The next command to the same bank issues no earlier than exactly PRECHARGE_LATENCY cycles after PRECHARGE, or ACTIVATION_LATENCY cycles after ACTIVATE.
  - The scheduler issues at exactly that cycle when no other constraint blocks.
  - Timers are per bank, decrement by 1 per cycle, saturate at 0, and are loaded only on a command to that bank.
- Bus rules:
  - READ and WRITE each load bus_timer so the next READ/WRITE is ≥ BURST_CYCLES later.
  - READ also loads rd_drain so a following WRITE is ≥ CAS_LATENCY+BURST_CYCLES after that READ.
  - Back-to-back READs may be spaced by BURST_CYCLES.
- Minimum latency, request accepted at edge T (timers idle):
  - Hit: command at cycle T+1.
  - Closed bank: ACTIVATE at T+1.
  - Conflict: PRECHARGE at T+1.
- cmd_valid_out is high exactly one cycle per command. Address and command fields are valid only with it; they hold their last value otherwise.
- Timer widths are sized to the largest loaded value; no wrap permitted.
- Different banks do not block each other except through the bus timers. A new request to a fresh bank may ACTIVATE while another bank's timer is still counting.

Optional Feature:
- Macro: DRAM_SCHED_PERF_EN.
- Defined:
  - Adds outputs row_hit_count_out and row_miss_count_out (32 bits each).
  - Counters increment at accept: hit→hit count, closed or conflict→miss count.
  - Both reset to 0 and saturate at 2^32−1.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then READ bg0 ba0 row 5 col 2 accepted at T → ACTIVATE row 5 at T+1; READ col 2 at T+9; req_ready_out=1 at T+10.
- Then READ bg0 ba0 row 5 col 3 accepted at U ≥ T+10 → READ at max(U+1, T+13); no ACTIVATE.
- Then READ bg0 ba0 row 9 accepted at V → PRECHARGE at V+1, ACTIVATE row 9 at V+6, READ at V+14.
- READ bg1 ba2 row 1 followed immediately by WRITE bg1 ba2 row 1 → WRITE issued ≥ 26 cycles after the READ; wdata_out equals req_data_in.
- Assert rst_in during PRE wait → cmd_valid_out=0 from reset onward; all banks closed; next request to that bank starts with ACTIVATE.
- With DRAM_SCHED_PERF_EN: sequence miss, hit, conflict → row_hit_count_out=1, row_miss_count_out=2.
